// File: rtl/ram_readback_checker_pkg.sv
// ram_readback_checker_pkg: FSM state encoding and default widths shared with the pattern controller
package ram_readback_checker_pkg;
  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, REPORT} state_t;
  localparam int DEF_AW = 8;
  localparam int DEF_DW = 8;
endpackage

// File: rtl/ram_readback_checker_delay_line.sv
// ram_chk_delay_line: RD_LAT-deep {valid, addr} shift register aligning issued reads with RAM q
module ram_chk_delay_line #(
  parameter int AW     = 8,
  parameter int RD_LAT = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic [AW-1:0] push_addr,
  output logic          cmp_vld,
  output logic [AW-1:0] cmp_addr
);
  logic [RD_LAT-1:0] vld;
  logic [AW-1:0]     adr [RD_LAT];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      for (int i = 0; i < RD_LAT; i++) adr[i] <= '0;
    end else begin
      vld[0] <= push && !flush;
      adr[0] <= push_addr;
      for (int i = 1; i < RD_LAT; i++) begin
        vld[i] <= vld[i-1] && !flush;
        adr[i] <= adr[i-1];
      end
    end
  end
  assign cmp_vld  = vld[RD_LAT-1];
  assign cmp_addr = adr[RD_LAT-1];
endmodule

// File: rtl/ram_readback_checker.sv
// ram_readback_checker: snoops controller wren/addr and RAM q, checks each read sweep against data == addr + EXP_OFFSET
module ram_readback_checker
  import ram_readback_checker_pkg::*;
#(
  parameter int AW         = DEF_AW,
  parameter int DW         = DEF_DW,
  parameter int RD_LAT     = 2,
  parameter int EXP_OFFSET = 0,
  parameter int SKIP_ADDR0 = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wren,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] q,
  output logic          done,
  output logic          pass,
  output logic          fail_sticky,
  output logic          protocol_err,
  output logic [15:0]   err_cnt,
  output logic [AW-1:0] first_err_addr,
  output logic [DW-1:0] first_err_data,
  output logic [15:0]   sweep_cnt
);
  localparam int DCW = $clog2(RD_LAT + 1);
  state_t         state;
  logic [1:0]     rst_sync;
  logic           rst_s_n;
  logic [AW:0]    rd_cnt, rd_nxt;
  logic [DCW-1:0] drn_cnt;
  logic [15:0]    run_cnt, run_nxt;
  logic           first_lat, push, abort, cmp_vld, miss;
  logic [AW-1:0]  cmp_addr;
  logic [DW-1:0]  exp_q;
  // async assert, release only after two clean clock edges
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_s_n = rst_sync[1];
  assign push    = !wren && (state == WRITE || state == READ);
  assign abort   = wren && (state == READ || state == DRAIN);
  assign rd_nxt  = rd_cnt + 1'b1;
  assign exp_q   = DW'(cmp_addr) + DW'(EXP_OFFSET);
  assign miss    = cmp_vld && !(SKIP_ADDR0 != 0 && cmp_addr == '0) && q != exp_q;
  assign run_nxt = (miss && run_cnt != 16'hFFFF) ? run_cnt + 16'd1 : run_cnt;
  ram_chk_delay_line #(.AW(AW), .RD_LAT(RD_LAT)) u_dl (
    .clk      (clk),
    .rst_n    (rst_s_n),
    .flush    (abort),
    .push     (push),
    .push_addr(addr),
    .cmp_vld  (cmp_vld),
    .cmp_addr (cmp_addr)
  );
  always_ff @(posedge clk or negedge rst_s_n) begin
    if (!rst_s_n) begin
      state          <= IDLE;
      rd_cnt         <= '0;
      drn_cnt        <= '0;
      run_cnt        <= '0;
      first_lat      <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      fail_sticky    <= 1'b0;
      protocol_err   <= 1'b0;
      err_cnt        <= '0;
      first_err_addr <= '0;
      first_err_data <= '0;
      sweep_cnt      <= '0;
    end else begin
      done    <= 1'b0;
      run_cnt <= run_nxt;
      if (miss) fail_sticky <= 1'b1;
      if (miss && !first_lat) begin
        first_lat      <= 1'b1;
        first_err_addr <= cmp_addr;
        first_err_data <= q;
      end
      case (state)
        IDLE: if (wren) state <= WRITE;
        WRITE: begin
          rd_cnt <= {{AW{1'b0}}, !wren};
          if (!wren) state <= READ;
        end
        READ: begin
          rd_cnt  <= rd_nxt;
          drn_cnt <= '0;
          if (rd_nxt[AW]) state <= DRAIN;
        end
        DRAIN: begin
          drn_cnt <= drn_cnt + 1'b1;
          if (drn_cnt == DCW'(RD_LAT - 1)) begin
            state     <= REPORT;
            done      <= 1'b1;
            pass      <= run_nxt == 16'd0;
            err_cnt   <= run_nxt;
            sweep_cnt <= sweep_cnt + 16'd1;
            run_cnt   <= '0;
          end
        end
        REPORT: state <= wren ? WRITE : IDLE;
        default: state <= IDLE;
      endcase
      // controller restarted a write pass before the read sweep finished
      if (abort) begin
        state        <= WRITE;
        protocol_err <= 1'b1;
        fail_sticky  <= 1'b1;
        run_cnt      <= '0;
      end
    end
  end
endmodule

// File: tb/tb_ram_readback_checker.sv
// tb_ram_readback_checker: scoreboard bench; two checkers share one pattern bus over differently configured RAM models
module tb_ram_readback_checker;
  typedef struct {
    logic        pass;
    logic [15:0] err;
    logic [7:0]  fea;
    logic [7:0]  fed;
    logic [15:0] sw;
    logic        fs;
    logic        pe;
  } exp_t;

  logic clk = 1'b0, rst_n = 1'b0, wren = 1'b0;
  logic [7:0] addr = 8'd0, addr_r, q_a, q_b;
  logic [7:0] ram_a [256], ram_b [256];
  logic inj5a = 1'b0, stuck3 = 1'b0, ff0 = 1'b0;
  logic done_a, pass_a, fs_a, pe_a, done_b, pass_b, fs_b, pe_b;
  logic [15:0] err_a, sw_a, err_b, sw_b;
  logic [7:0] fea_a, fed_a, fea_b, fed_b;
  logic done_a_q = 1'b0, done_b_q = 1'b0;
  exp_t qa[$], qb[$];
  int n_vec = 0, n_bad = 0;

  always #5 clk = ~clk;

  // A: 2-cycle registered read, addr 0 holds junk; B: 1-cycle read, pattern addr+1
  always @(posedge clk) begin
    if (wren) begin
      ram_a[addr] <= (addr == 8'd0) ? 8'hEE : addr;
      ram_b[addr] <= addr + 8'd1;
    end
    addr_r <= addr;
    q_a <= (inj5a && addr_r == 8'h5A) ? 8'h00 :
           (stuck3 && addr_r != 8'd0) ? (ram_a[addr_r] & 8'hF7) : ram_a[addr_r];
    q_b <= (ff0 && addr == 8'd0) ? 8'hFF : ram_b[addr];
  end

  ram_readback_checker #(.RD_LAT(2)) u_a (
    .clk(clk), .rst_n(rst_n), .wren(wren), .addr(addr), .q(q_a),
    .done(done_a), .pass(pass_a), .fail_sticky(fs_a), .protocol_err(pe_a),
    .err_cnt(err_a), .first_err_addr(fea_a), .first_err_data(fed_a), .sweep_cnt(sw_a)
  );

  ram_readback_checker #(.RD_LAT(1), .EXP_OFFSET(1), .SKIP_ADDR0(0)) u_b (
    .clk(clk), .rst_n(rst_n), .wren(wren), .addr(addr), .q(q_b),
    .done(done_b), .pass(pass_b), .fail_sticky(fs_b), .protocol_err(pe_b),
    .err_cnt(err_b), .first_err_addr(fea_b), .first_err_data(fed_b), .sweep_cnt(sw_b)
  );

  function automatic exp_t mk(input logic p, input logic [15:0] e, input logic [7:0] fa, input logic [7:0] fd,
                              input logic [15:0] s, input logic f, input logic pr);
    exp_t r;
    r.pass = p; r.err = e; r.fea = fa; r.fed = fd; r.sw = s; r.fs = f; r.pe = pr;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp(input string t, input exp_t a, input exp_t e);
    chk({t, "_pass"}, 32'(a.pass), 32'(e.pass));
    chk({t, "_err_cnt"}, 32'(a.err), 32'(e.err));
    chk({t, "_first_err_addr"}, 32'(a.fea), 32'(e.fea));
    chk({t, "_first_err_data"}, 32'(a.fed), 32'(e.fed));
    chk({t, "_sweep_cnt"}, 32'(a.sw), 32'(e.sw));
    chk({t, "_fail_sticky"}, 32'(a.fs), 32'(e.fs));
    chk({t, "_protocol_err"}, 32'(a.pe), 32'(e.pe));
  endtask

  // monitor: every done pulse must match the oldest pending expectation
  always @(negedge clk) begin
    if (done_a) begin
      chk("a_done_back_to_back", 32'(done_a_q), 32'd0);
      chk("a_done_expected", 32'(qa.size() != 0), 32'd1);
      if (qa.size() != 0) cmp("a", mk(pass_a, err_a, fea_a, fed_a, sw_a, fs_a, pe_a), qa.pop_front());
    end
    if (done_b) begin
      chk("b_done_back_to_back", 32'(done_b_q), 32'd0);
      chk("b_done_expected", 32'(qb.size() != 0), 32'd1);
      if (qb.size() != 0) cmp("b", mk(pass_b, err_b, fea_b, fed_b, sw_b, fs_b, pe_b), qb.pop_front());
    end
    done_a_q <= done_a;
    done_b_q <= done_b;
  end

  task automatic check_zero(input string t);
    cmp({t, "_a"}, mk(pass_a, err_a, fea_a, fed_a, sw_a, fs_a, pe_a), mk(0, 0, 0, 0, 0, 0, 0));
    cmp({t, "_b"}, mk(pass_b, err_b, fea_b, fed_b, sw_b, fs_b, pe_b), mk(0, 0, 0, 0, 0, 0, 0));
    chk({t, "_done_a"}, 32'(done_a), 32'd0);
    chk({t, "_done_b"}, 32'(done_b), 32'd0);
  endtask

  // stop_at < 256 ends the read pass early: by wren=1, or by asserting reset when rst_stop is set
  task automatic sweep(input int stop_at, input bit rst_stop, input exp_t ea, input exp_t eb);
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      wren = 1'b1;
      addr = 8'(i);
    end
    if (stop_at > 255) begin
      qa.push_back(ea);
      qb.push_back(eb);
    end
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      addr = 8'(i);
      wren = (i == stop_at) && !rst_stop;
      if (i == stop_at) begin
        if (rst_stop) begin
          #1 rst_n = 1'b0;
        end
        return;
      end
    end
    repeat (8) begin
      @(negedge clk);
      wren = 1'b0;
      addr = 8'd0;
    end
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst_n = 1'b0;
    wren = 1'b0;
    addr = 8'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    sweep(256, 1'b0, mk(1, 0, 8'h00, 8'h00, 1, 0, 0), mk(1, 0, 8'h00, 8'h00, 1, 0, 0));
    inj5a = 1'b1;
    ff0 = 1'b1;
    sweep(256, 1'b0, mk(0, 1, 8'h5A, 8'h00, 2, 1, 0), mk(0, 1, 8'h00, 8'hFF, 2, 1, 0));
    inj5a = 1'b0;
    ff0 = 1'b0;
    do_reset();
    stuck3 = 1'b1;
    sweep(256, 1'b0, mk(0, 128, 8'h08, 8'h00, 1, 1, 0), mk(1, 0, 8'h00, 8'h00, 1, 0, 0));
    stuck3 = 1'b0;
    sweep(256, 1'b0, mk(1, 0, 8'h08, 8'h00, 2, 1, 0), mk(1, 0, 8'h00, 8'h00, 2, 0, 0));
    sweep(100, 1'b0, mk(0, 0, 0, 0, 0, 0, 0), mk(0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    chk("proto_a_protocol_err", 32'(pe_a), 32'd1);
    chk("proto_b_protocol_err", 32'(pe_b), 32'd1);
    chk("proto_a_fail_sticky", 32'(fs_a), 32'd1);
    chk("proto_b_fail_sticky", 32'(fs_b), 32'd1);
    chk("proto_a_sweep_cnt", 32'(sw_a), 32'd2);
    chk("proto_b_sweep_cnt", 32'(sw_b), 32'd2);
    sweep(256, 1'b0, mk(1, 0, 8'h08, 8'h00, 3, 1, 1), mk(1, 0, 8'h00, 8'h00, 3, 1, 1));
    sweep(37, 1'b1, mk(0, 0, 0, 0, 0, 0, 0), mk(0, 0, 0, 0, 0, 0, 0));
    #1;
    check_zero("mid_read_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wren = 1'b0;
    addr = 8'd0;
    repeat (6) @(negedge clk);
    sweep(256, 1'b0, mk(1, 0, 8'h00, 8'h00, 1, 0, 0), mk(1, 0, 8'h00, 8'h00, 1, 0, 0));
    repeat (10) @(negedge clk);
    chk("a_pending_results", 32'(qa.size()), 32'd0);
    chk("b_pending_results", 32'(qb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
